// File: rtl/uart_pkg.sv
// Shared UART types and constants: capture FSM states, divisor limits and the byte type.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_LOAD,
    CAPTURE
  } rx_ctrl_state_t;

  typedef logic [7:0] uart_byte_t;

  // A divisor of 0 or 1 cannot produce a one-cycle pulse followed by a gap.
  localparam int DIV_MIN = 2;
  localparam int DIV_115200_100MHZ = 108;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream and status bus between uart_rx_ctrl (master) and the register/bus logic (slave).
interface uart_rx_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  import uart_pkg::*;

  localparam int CNT_W = fifo_count_width(FIFO_DEPTH);

  uart_byte_t       m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             overrun;
  logic             clr_overrun;
  logic             rx_timeout;

  modport master (
    output m_data,
    output m_valid,
    output fifo_count,
    output overrun,
    output rx_timeout,
    input  m_ready,
    input  clr_overrun
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  fifo_count,
    input  overrun,
    input  rx_timeout,
    output m_ready,
    output clr_overrun
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO; a push while full is accepted only when a pop frees the slot.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                push_i,
  input  uart_byte_t                          data_i,
  input  logic                                pop_i,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [fifo_count_width(DEPTH)-1:0]  count_o,
  output uart_byte_t                          head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_width(DEPTH);

  uart_byte_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: bclkx8 divider, receiver reset, frame capture FSM and byte FIFO.
// Define UART_RX_TIMEOUT_EN to build the idle-timeout counter behind rx_timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int DIV_W         = 16,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  output logic             bclkx8,
  output logic             rx_rst,
  input  logic             rx_status,
  input  uart_byte_t       rhr,
  uart_rx_ctrl_if.master   m_if
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("uart_rx_ctrl: TIMEOUT_TICKS must be at least 1");
  end

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap;
  logic             rx_rst_q;
  rx_ctrl_state_t   state_q, state_d;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overrun_q, overrun_d;

  // The divisor is latched at each wrap so a mid-period change never truncates a period.
  assign div_eff = (baud_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : baud_div;
  assign wrap    = (cnt_q == (div_q - DIV_W'(1)));
  assign bclkx8  = rx_en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (!rx_en || wrap) begin
      cnt_d = '0;
      div_d = div_eff;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DIV_MIN);
      rx_rst_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rx_rst_q <= ~rx_en;
    end
  end

  assign rx_rst = rx_rst_q;

  // The receiver loads RHR on the first tick after it goes idle, so the byte is taken one cycle later.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (!rx_en || rx_rst_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (rx_status)  state_d = BUSY;
        BUSY:      if (!rx_status) state_d = WAIT_LOAD;
        WAIT_LOAD: if (bclkx8)     state_d = CAPTURE;
        CAPTURE: begin
          push    = 1'b1;
          state_d = IDLE;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pop          = m_if.m_ready & ~fifo_empty;
  assign m_if.m_valid = ~fifo_empty;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (rhr),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (m_if.fifo_count),
    .head_o  (m_if.m_data)
  );

  // A same-cycle pop makes room, so only an unrelieved push into a full FIFO is an overrun.
  always_comb begin
    overrun_d = overrun_q;
    if (push && fifo_full && !pop) begin
      overrun_d = 1'b1;
    end else if (m_if.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign m_if.overrun = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] tick_q, tick_d;

  // Saturating at the limit keeps the flag asserted until traffic or an empty FIFO restarts it.
  always_comb begin
    tick_d = tick_q;
    if (push || pop || fifo_empty) begin
      tick_d = '0;
    end else if (state_q == IDLE && bclkx8 && tick_q != TW'(TIMEOUT_TICKS)) begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign m_if.rx_timeout = (tick_q == TW'(TIMEOUT_TICKS));
`else
  assign m_if.rx_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver datapath.
- Generates the receiver's bclkx8 sampling tick from a programmable divisor.
- Holds the receiver in reset while reception is disabled.
- Detects frame completion from rx_status and captures RHR into a small first-word-fall-through byte FIFO with a valid/ready output.
- Sits between the receiver and the bus-side register/interface logic.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor.
- TIMEOUT_TICKS, 320, bclkx8 ticks of inactivity before rx_timeout (only with UART_RX_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_en  in  1  1 = receive enabled.
- baud_div  in  DIV_W  sys_clk cycles per bclkx8 tick.
- bclkx8  out  1  sampling tick to receiver, one sys_clk wide.
- rx_rst  out  1  active-high reset to receiver.
- rx_status  in  1  receiver busy (high during START/DATA).
- rhr  in  8  receiver holding register.
- m_data  out  8  FIFO head byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer pops head when m_valid & m_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overrun  out  1  sticky: byte dropped because FIFO full.
- clr_overrun  in  1  clears overrun.
- rx_timeout  out  1  idle-timeout flag.

Behaviour:
Reset values:
- Asserted asynchronously while rst_n=0: bclkx8=0, rx_rst=1, m_valid=0, m_data=0, fifo_count=0, overrun=0, rx_timeout=0.
- FSM=IDLE, divider=0, FIFO pointers=0.

Divisor:
- Effective divisor D = max(baud_div, 2).
- Counter runs 0..D-1; bclkx8=1 for exactly the cycle in which counter==D-1, so the period is D cycles.
- baud_div changes take effect at the next wrap.
- rx_en=0 holds the counter at 0 and bclkx8 at 0.

rx_rst:
- Registered ~rx_en: goes high the cycle after rx_en falls, low the cycle after rx_en rises.

Capture FSM (all transitions registered):
- IDLE: on rx_status=1 -> BUSY.
- BUSY: on rx_status=0 (falling edge) -> WAIT_LOAD.
- WAIT_LOAD: on a bclkx8 pulse -> CAPTURE. The receiver loads RHR on this tick.
- CAPTURE: one cycle; samples rhr, issues push, -> IDLE.
- rx_en=0 or rx_rst=1 in any state -> IDLE next cycle. The partial frame is discarded and FIFO contents are preserved.
- Latency: m_valid rises the cycle after CAPTURE when the FIFO was empty.

FIFO:
- First-word-fall-through: m_data is always the head entry, m_valid = (fifo_count != 0).
- A pop takes effect at the clock edge.
- Push while full and no pop: byte dropped, overrun set.
- Push and pop in the same cycle:
  - If full, the pop frees the slot, the push is accepted, count is unchanged, and there is no overrun.
  - If empty, no pop occurs (m_valid=0) and count becomes 1.
- Pointers wrap modulo FIFO_DEPTH; count saturates at 0 and FIFO_DEPTH by construction.
- overrun: a set and clr_overrun in the same cycle leaves it set (set wins).

Optional Feature:
Macro: UART_RX_TIMEOUT_EN

Defined:
- A tick counter increments on each bclkx8 while FSM=IDLE and the FIFO is non-empty.
- The counter resets to 0 on any push, any pop, or when the FIFO is empty.
- rx_timeout goes to 1 when the counter reaches TIMEOUT_TICKS and stays 1 until the next push or pop, or until the FIFO empties.

Undefined:
- No counter is built and rx_timeout is tied to 0. The port is always present.

Decomposition:
Shared package uart_pkg:
- rx_ctrl_state_t enum: IDLE, BUSY, WAIT_LOAD, CAPTURE.
- DIV_MIN=2.
- Example divisor constant DIV_115200_100MHZ=108.
- Shared byte typedef.

Sub-module uart_byte_fifo (parameterised on depth):
- Synchronous FWFT FIFO with push, pop, full, empty and count.
- Overrun logic stays in uart_rx_ctrl.

Test Plan:
1. baud_div=108, rx_en=1 -> bclkx8 pulses exactly every 108 sys_clk cycles, 1 cycle wide. baud_div=0 or 1 -> period 2.
2. Receiver model completes frame 0xA5, m_ready=0 -> FSM IDLE->BUSY->WAIT_LOAD->CAPTURE, then m_valid=1, m_data=0xA5, fifo_count=1.
3. Five frames 0x01..0x05, m_ready=0, depth 4 -> fifo_count=4, overrun=1, 0x05 dropped. Popping yields 0x01..0x04 in order. A clr_overrun pulse gives overrun=0. clr_overrun asserted on the cycle of a new overrun -> overrun stays 1.
4. FIFO full, m_ready=1 during the CAPTURE cycle -> count stays 4, overrun stays 0, the new byte appears after three further pops.
5. rx_en dropped mid-DATA with 2 bytes queued -> rx_rst=1 next cycle, bclkx8 stays 0, FSM=IDLE, no push, fifo_count=2 retained.
6. rst_n pulsed low asynchronously mid-frame, between clock edges -> all outputs take their reset values immediately. With UART_RX_TIMEOUT_EN: 1 byte queued and idle for 320 ticks -> rx_timeout=1, cleared by the pop.
